apa102_rx: RTL and testbench

Serial decoder for the APA102 LED strip protocol: the strip-side counterpart of the APA102 driver used by the top-level LED state machine. It samples `led_clk`/`led_data` in the `clk` domain and recovers start-of-frame, pixel and end-of-frame words. Each pixel is presented as a one-cycle strobe with brightness, RGB and index. It serves in loopback self-test and as the driver's bench checker, and lets a board act as a downstream pixel emulator.

---
 rtl/apa102_rx_pkg.sv | 42 ++++
 rtl/apa102_rx_if.sv | 31 +++
 rtl/apa102_rx_sync_rise.sv | 26 ++
 rtl/apa102_rx.sv | 139 +++++++++++++
 tb/tb_apa102_rx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apa102_rx_pkg.sv
// apa102_rx shared types and constants.
// Word layout of the APA102 serial protocol.
package apa102_pkg;

  typedef enum logic {HUNT, FRAME} state_t;

  localparam logic [31:0] APA_SOF_WORD = 32'h0000_0000;
  localparam logic [31:0] APA_EOF_WORD = 32'hFFFF_FFFF;
  localparam logic [2:0]  APA_PX_HDR   = 3'b111;

  localparam int HDR_HI = 31;
  localparam int HDR_LO = 29;
  localparam int BRT_HI = 28;
  localparam int BRT_LO = 24;
  localparam int BLU_HI = 23;
  localparam int BLU_LO = 16;
  localparam int GRN_HI = 15;
  localparam int GRN_LO = 8;
  localparam int RED_HI = 7;
  localparam int RED_LO = 0;

  typedef struct packed {
    logic [4:0] bright;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } apa_px_t;

  function automatic apa_px_t px_fields(input logic [31:0] w);
    apa_px_t p;
    p.bright = w[BRT_HI:BRT_LO];
    p.blue   = w[BLU_HI:BLU_LO];
    p.green  = w[GRN_HI:GRN_LO];
    p.red    = w[RED_HI:RED_LO];
    return p;
  endfunction

  function automatic logic is_px_hdr(input logic [31:0] w);
    return w[HDR_HI:HDR_LO] == APA_PX_HDR;
  endfunction

endpackage

// File: rtl/apa102_rx_if.sv
// apa102_rx decoded-output bundle.
// master: decoder side, slave: consumer side.
interface apa102_rx_if #(
  parameter int IDX_W = 16
);
  logic             frame_start;
  logic             frame_end;
  logic             pixel_valid;
  logic             proto_error;
  logic [4:0]       pixel_bright;
  logic [7:0]       pixel_red;
  logic [7:0]       pixel_green;
  logic [7:0]       pixel_blue;
  logic [IDX_W-1:0] pixel_index;

  modport master (
    output frame_start, frame_end,
    output pixel_valid, proto_error,
    output pixel_bright, pixel_red,
    output pixel_green, pixel_blue,
    output pixel_index
  );

  modport slave (
    input frame_start, frame_end,
    input pixel_valid, proto_error,
    input pixel_bright, pixel_red,
    input pixel_green, pixel_blue,
    input pixel_index
  );
endinterface

// File: rtl/apa102_rx_sync_rise.sv
// 2-FF synchroniser with a registered copy
// for rise detection; q and rise share alignment.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/apa102_rx.sv
// APA102 strip-side decoder: recovers SOF,
// pixel and EOF words from led_clk/led_data.
module apa102_rx #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic led_clk,
  input  logic led_data,
  apa102_rx_if.master px
);
  import apa102_pkg::*;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  logic clk_q_unused, bit_rise;
  logic dat_s, data_rise_unused;

  sync_rise u_clk_sync (
    .clk(clk), .rst(rst), .d(led_clk),
    .q(clk_q_unused), .rise(bit_rise)
  );

  sync_rise u_dat_sync (
    .clk(clk), .rst(rst), .d(led_data),
    .q(dat_s), .rise(data_rise_unused)
  );

  state_t           state, state_n;
  logic [4:0]       bit_cnt, bit_cnt_n;
  logic [5:0]       run, run_n;
  logic [15:0]      idle, idle_n;
  logic [30:0]      shreg;
  logic [31:0]      word;
  logic [IDX_W-1:0] idx, idx_n;
  logic             sof_n, eof_n;
  logic             pxv_n, err_n;
  apa_px_t          f;

  // Word as it stands once the current bit lands.
  assign word = {shreg, dat_s};
  assign f    = px_fields(word);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    run_n     = run;
    idx_n     = idx;
    idle_n    = (idle == 16'hFFFF) ? idle : idle + 16'd1;
    sof_n     = 1'b0;
    eof_n     = 1'b0;
    pxv_n     = 1'b0;
    err_n     = 1'b0;
    if (bit_rise) begin
      idle_n    = '0;
      bit_cnt_n = bit_cnt + 5'd1;
      unique case (state)
        HUNT: begin
          run_n = dat_s ? 6'd0 : run + 6'd1;
          if (!dat_s && run == 6'd31) begin
            sof_n     = 1'b1;
            idx_n     = '0;
            bit_cnt_n = '0;
            run_n     = '0;
            state_n   = FRAME;
          end
        end
        FRAME: begin
          if (bit_cnt == 5'd31) begin
            unique case (1'b1)
              (word == APA_SOF_WORD): begin
                sof_n = 1'b1;
                idx_n = '0;
              end
              (word == APA_EOF_WORD): begin
                eof_n   = 1'b1;
                state_n = HUNT;
              end
              (is_px_hdr(word) && word != APA_EOF_WORD): begin
                pxv_n = 1'b1;
                idx_n = (idx == IDX_MAX) ? idx : idx + IDX_W'(1);
              end
              default: begin
                err_n   = 1'b1;
                run_n   = '0;
                state_n = HUNT;
              end
            endcase
          end
        end
      endcase
    end else if (state == FRAME && bit_cnt != '0
                 && idle == TO_CNT) begin
      err_n     = 1'b1;
      bit_cnt_n = '0;
      state_n   = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HUNT;
      bit_cnt         <= '0;
      run             <= '0;
      idle            <= '0;
      shreg           <= '0;
      idx             <= '0;
      px.frame_start  <= 1'b0;
      px.frame_end    <= 1'b0;
      px.pixel_valid  <= 1'b0;
      px.proto_error  <= 1'b0;
      px.pixel_bright <= '0;
      px.pixel_red    <= '0;
      px.pixel_green  <= '0;
      px.pixel_blue   <= '0;
      px.pixel_index  <= '0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      run            <= run_n;
      idle           <= idle_n;
      idx            <= idx_n;
      px.frame_start <= sof_n;
      px.frame_end   <= eof_n;
      px.pixel_valid <= pxv_n;
      px.proto_error <= err_n;
      if (bit_rise) shreg <= word[30:0];
      if (pxv_n) begin
        px.pixel_bright <= f.bright;
        px.pixel_red    <= f.red;
        px.pixel_green  <= f.green;
        px.pixel_blue   <= f.blue;
        px.pixel_index  <= idx;
      end
    end
  end
endmodule

// File: tb/tb_apa102_rx.sv
// Bench for apa102_rx: word-level model plus
// per-cycle compare against two decoder widths.
module tb_apa102_rx;
  localparam int TO  = 1024;
  localparam int IW  = 16;
  localparam int IW2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led_clk = 1'b0;
  logic led_data = 1'b0;

  always #5 clk = ~clk;

  apa102_rx_if #(.IDX_W(IW))  px ();
  apa102_rx_if #(.IDX_W(IW2)) px2 ();

  apa102_rx #(.TIMEOUT_CYCLES(TO), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .led_clk(led_clk),
    .led_data(led_data), .px(px)
  );

  apa102_rx #(.TIMEOUT_CYCLES(TO), .IDX_W(IW2)) dut2 (
    .clk(clk), .rst(rst), .led_clk(led_clk),
    .led_data(led_data), .px(px2)
  );

  typedef enum int {K_NONE, K_SOF, K_EOF, K_PIX, K_ERR} kind_t;
  typedef struct {
    kind_t       k;
    logic [31:0] w;
    int          idx;
  } ev_t;

  ev_t evq[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cnt [0:4];

  bit          m_frame;
  int          m_run, m_nb, m_next;
  logic [31:0] m_word;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic kind_t kind_of(input logic s, input logic e,
                                    input logic p, input logic r);
    if (s) return K_SOF;
    if (e) return K_EOF;
    if (p) return K_PIX;
    if (r) return K_ERR;
    return K_NONE;
  endfunction

  task automatic push(input kind_t k, input logic [31:0] w, input int i);
    ev_t e;
    e.k = k; e.w = w; e.idx = i;
    evq.push_back(e);
  endtask

  // Protocol model: hunt for 32 zeros, then classify whole words.
  task automatic model_bit(input logic b);
    if (!m_frame) begin
      m_run = b ? 0 : m_run + 1;
      if (m_run == 32) begin
        push(K_SOF, 32'h0, 0);
        m_frame = 1; m_nb = 0; m_next = 0; m_run = 0;
      end
    end else begin
      m_word = {m_word[30:0], b};
      m_nb++;
      if (m_nb == 32) begin
        m_nb = 0;
        if (m_word == 32'h0) begin
          push(K_SOF, m_word, 0); m_next = 0;
        end else if (m_word == 32'hFFFF_FFFF) begin
          push(K_EOF, m_word, 0); m_frame = 0; m_run = 0;
        end else if (m_word[31:29] == 3'b111) begin
          push(K_PIX, m_word, m_next); m_next++;
        end else begin
          push(K_ERR, m_word, 0); m_frame = 0; m_run = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_run = 0; m_nb = 0; m_next = 0; m_word = '0;
  endtask

  task automatic send_bit(input logic b);
    led_clk = 1'b0;
    led_data = b;
    repeat (2) @(negedge clk);
    led_clk = 1'b1;
    repeat (2) @(negedge clk);
    model_bit(b);
  endtask

  task automatic send_word(input logic [31:0] w, input int n = 32);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic gap(input int n);
    led_clk = 1'b0;
    if (m_frame && m_nb != 0 && n > TO + 8) begin
      push(K_ERR, 32'h0, 0);
      m_frame = 0; m_nb = 0; m_run = 0;
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    led_clk = 1'b0;
    repeat (8) @(negedge clk);
    chk("queue_drained", 64'(evq.size()), 64'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_strobes"},
        {px.frame_start, px.frame_end, px.pixel_valid, px.proto_error},
        4'b0);
    chk({nm, "_fields"},
        {px.pixel_bright, px.pixel_red, px.pixel_green,
         px.pixel_blue, px.pixel_index}, 45'd0);
    chk({nm, "_index_n2"}, 64'(px2.pixel_index), 64'd0);
  endtask

  task automatic do_reset();
    led_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [4:0] h_b;
  logic [7:0] h_r, h_g, h_bl;
  int         h_i, h_i2;

  always @(posedge clk) begin : cmp
    ev_t   ev;
    kind_t k, k2;
    int    ns;
    #1;
    if (rst) begin
      h_b = '0; h_r = '0; h_g = '0; h_bl = '0; h_i = 0; h_i2 = 0;
    end else begin
      k  = kind_of(px.frame_start, px.frame_end,
                   px.pixel_valid, px.proto_error);
      k2 = kind_of(px2.frame_start, px2.frame_end,
                   px2.pixel_valid, px2.proto_error);
      ns = int'(px.frame_start) + int'(px.frame_end)
         + int'(px.pixel_valid) + int'(px.proto_error);
      chk("strobe_excl", 64'(ns <= 1), 64'd1);
      if (k != K_NONE) begin
        cnt[int'(k)]++;
        if (evq.size() == 0) begin
          chk("unexpected_strobe", 64'(k), 64'(K_NONE));
        end else begin
          ev = evq.pop_front();
          chk("strobe_kind", 64'(k), 64'(ev.k));
          chk("strobe_kind_n2", 64'(k2), 64'(ev.k));
          if (ev.k == K_PIX) begin
            h_b  = ev.w[28:24];
            h_bl = ev.w[23:16];
            h_g  = ev.w[15:8];
            h_r  = ev.w[7:0];
            h_i  = sat(ev.idx, IW);
            h_i2 = sat(ev.idx, IW2);
          end
        end
      end else begin
        chk("no_strobe_n2", 64'(k2), 64'(K_NONE));
      end
      chk("fields",
          {px.pixel_bright, px.pixel_blue, px.pixel_green,
           px.pixel_red, 16'(px.pixel_index)},
          {h_b, h_bl, h_g, h_r, 16'(h_i)});
      chk("fields_n2",
          {px2.pixel_bright, px2.pixel_blue, px2.pixel_green,
           px2.pixel_red, 2'(px2.pixel_index)},
          {h_b, h_bl, h_g, h_r, 2'(h_i2)});
    end
  end

  initial begin
    int base, e0, p0;
    logic [31:0] w;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Basic frame
    send_word(32'h0);
    send_word(32'hE510_2030);
    send_word(32'hFFFF_FFFF);
    drain();
    chk("t1_bright", 64'(px.pixel_bright), 64'd5);
    chk("t1_blue", 64'(px.pixel_blue), 64'h10);
    chk("t1_green", 64'(px.pixel_green), 64'h20);
    chk("t1_red", 64'(px.pixel_red), 64'h30);
    chk("t1_index", 64'(px.pixel_index), 64'd0);
    chk("t1_counts", {32'(cnt[1]), 32'(cnt[2])}, {32'd1, 32'd1});
    chk("t1_pix_err", {32'(cnt[3]), 32'(cnt[4])}, {32'd1, 32'd0});

    // 300-pixel frame with random colours (loopback data)
    base = cnt[3];
    send_word(32'h0);
    for (int i = 0; i < 300; i++) begin
      w = {3'b111, 5'($urandom), 24'($urandom)};
      if (w == 32'hFFFF_FFFF) w[7:0] = 8'h00;
      send_word(w);
    end
    drain();
    chk("t2_count", 64'(cnt[3] - base), 64'd300);
    chk("t2_last_index", 64'(px.pixel_index), 64'd299);
    chk("t2_sat_index_n2", 64'(px2.pixel_index), 64'd3);
    send_word(32'h0);
    send_word(32'hE711_2233);
    drain();
    chk("t2_index_restart", 64'(px.pixel_index), 64'd0);
    chk("t2_bright", 64'(px.pixel_bright), 64'd7);
    chk("t2_red", 64'(px.pixel_red), 64'h33);

    // Bad header, then ignored pixel until fresh SOF
    e0 = cnt[4];
    send_word(32'h4000_0000);
    drain();
    chk("t3_err", 64'(cnt[4] - e0), 64'd1);
    p0 = cnt[3];
    send_word(32'hE510_2031);
    drain();
    chk("t3_ignored", 64'(cnt[3]), 64'(p0));
    send_word(32'h0);
    send_word(32'hE1AA_BBCC);
    drain();
    chk("t3_index", 64'(px.pixel_index), 64'd0);
    chk("t3_rgb", {px.pixel_red, px.pixel_green, px.pixel_blue},
        24'hCCBBAA);
    chk("t3_bright", 64'(px.pixel_bright), 64'd1);

    // Timeout mid-word
    e0 = cnt[4];
    send_word(32'hE312_3456, 10);
    gap(1100);
    drain();
    chk("t4_err_once", 64'(cnt[4] - e0), 64'd1);
    send_word(32'h0);
    send_word(32'hE2AB_CDEF);
    drain();
    chk("t4_index", 64'(px.pixel_index), 64'd0);
    chk("t4_red", 64'(px.pixel_red), 64'hEF);

    // Reset mid-word
    send_word(32'hE401_0203, 20);
    do_reset();
    check_zero("t5_after_rst");
    p0 = cnt[3];
    send_word(32'hE510_2031);
    drain();
    chk("t5_ignored", 64'(cnt[3]), 64'(p0));
    e0 = cnt[2];
    send_word(32'h0);
    send_word(32'hE604_0506);
    send_word(32'hFFFF_FFFF);
    drain();
    chk("t5_rgb", {px.pixel_red, px.pixel_green, px.pixel_blue},
        24'h060504);
    chk("t5_eof", 64'(cnt[2] - e0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
